// File: rtl/nco_ctrl.sv
// rtl/nco_ctrl.sv - NCO command sequencer: FTW writes, counted/continuous runs, virtual-Z.
// Optional command FIFO in front of the FSM when NCO_CTRL_CMD_FIFO_EN is defined.
module nco_ctrl #(
    parameter int N            = 22,
    parameter int Z_CORR_WIDTH = 12,
    parameter int CNT_WIDTH    = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [N-1:0]            cmd_data,
    output logic                    ftw_wr_en,
    output logic [N-1:0]            ftw_out,
    output logic                    z_corr_wr_en,
    output logic [Z_CORR_WIDTH-1:0] z_corr_out,
    output logic                    phase_wr_en,
    output logic                    z_corr_mode,
    output logic                    busy,
    output logic                    run_done
);
    typedef enum logic [2:0] {
        S_IDLE, S_RUN_CNT, S_RUN_CONT, S_VZ_LOAD, S_VZ_APPLY
    } state_t;

    localparam logic [1:0] OP_SET_FTW = 2'b00;
    localparam logic [1:0] OP_VZ      = 2'b01;
    localparam logic [1:0] OP_RUN     = 2'b10;
    localparam logic [1:0] OP_STOP    = 2'b11;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    ret_q, ret_d;
    logic [Z_CORR_WIDTH-1:0] z_q, z_d;

    logic                    ftw_wr_en_q, ftw_wr_en_d;
    logic [N-1:0]            ftw_out_q, ftw_out_d;
    logic                    z_corr_wr_en_q, z_corr_wr_en_d;
    logic [Z_CORR_WIDTH-1:0] z_corr_out_q, z_corr_out_d;
    logic                    phase_wr_en_q, phase_wr_en_d;
    logic                    z_corr_mode_q, z_corr_mode_d;
    logic                    busy_q, busy_d;
    logic                    run_done_q, run_done_d;

    logic                    fsm_valid, fsm_ready, accept;
    logic [1:0]              fsm_op;
    logic [N-1:0]            fsm_data;
    logic [CNT_WIDTH-1:0]    run_k;

    assign fsm_ready = rst && (state_q == S_IDLE || state_q == S_RUN_CONT);
    assign accept    = fsm_valid && fsm_ready;
    assign run_k     = fsm_data[CNT_WIDTH-1:0];

`ifdef NCO_CTRL_CMD_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [N+1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]  wr_ptr_q, rd_ptr_q;
    logic         fifo_full, fifo_empty, push;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign cmd_ready  = rst && !fifo_full;
    assign push       = cmd_valid && cmd_ready;
    assign fsm_valid  = !fifo_empty;
    assign {fsm_op, fsm_data} = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= {cmd_op, cmd_data};
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (accept) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end
`else
    assign cmd_ready = fsm_ready;
    assign fsm_valid = cmd_valid & (FIFO_DEPTH > 0);
    assign fsm_op    = cmd_op;
    assign fsm_data  = cmd_data;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            ret_q          <= 1'b0;
            z_q            <= '0;
            ftw_wr_en_q    <= 1'b0;
            ftw_out_q      <= '0;
            z_corr_wr_en_q <= 1'b0;
            z_corr_out_q   <= '0;
            phase_wr_en_q  <= 1'b0;
            z_corr_mode_q  <= 1'b0;
            busy_q         <= 1'b0;
            run_done_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ret_q          <= ret_d;
            z_q            <= z_d;
            ftw_wr_en_q    <= ftw_wr_en_d;
            ftw_out_q      <= ftw_out_d;
            z_corr_wr_en_q <= z_corr_wr_en_d;
            z_corr_out_q   <= z_corr_out_d;
            phase_wr_en_q  <= phase_wr_en_d;
            z_corr_mode_q  <= z_corr_mode_d;
            busy_q         <= busy_d;
            run_done_q     <= run_done_d;
        end
    end

    // ret_q remembers whether VZ was issued from RUN_CONT so the run resumes after APPLY
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ret_d   = ret_q;
        z_d     = z_q;
        case (state_q)
            S_IDLE, S_RUN_CONT: begin
                if (accept) begin
                    case (fsm_op)
                        OP_VZ: begin
                            ret_d   = (state_q == S_RUN_CONT);
                            z_d     = fsm_data[Z_CORR_WIDTH-1:0];
                            state_d = S_VZ_LOAD;
                        end
                        OP_RUN: begin
                            if (run_k == '0) begin
                                state_d = S_RUN_CONT;
                            end else begin
                                state_d = S_RUN_CNT;
                                cnt_d   = run_k;
                            end
                        end
                        OP_STOP:    state_d = S_IDLE;
                        OP_SET_FTW: state_d = state_q;
                        default:    state_d = state_q;
                    endcase
                end
            end
            S_RUN_CNT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_IDLE;
                end
            end
            S_VZ_LOAD:  state_d = S_VZ_APPLY;
            S_VZ_APPLY: state_d = ret_q ? S_RUN_CONT : S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered one cycle after acceptance
    always_comb begin
        ftw_wr_en_d    = accept && (fsm_op == OP_SET_FTW);
        ftw_out_d      = ftw_wr_en_d ? fsm_data : ftw_out_q;
        phase_wr_en_d  = (state_d == S_RUN_CNT) || (state_d == S_RUN_CONT) ||
                         (state_d == S_VZ_APPLY) || ((state_d == S_VZ_LOAD) && ret_d);
        z_corr_wr_en_d = (state_d == S_VZ_LOAD) || (state_d == S_VZ_APPLY);
        z_corr_out_d   = (state_d == S_VZ_LOAD) ? z_d : '0;
        z_corr_mode_d  = (state_d == S_VZ_APPLY);
        busy_d         = (state_d != S_IDLE);
        run_done_d     = (state_d == S_RUN_CNT) && (cnt_d == CNT_ONE);
    end

    assign ftw_wr_en    = ftw_wr_en_q;
    assign ftw_out      = ftw_out_q;
    assign z_corr_wr_en = z_corr_wr_en_q;
    assign z_corr_out   = z_corr_out_q;
    assign phase_wr_en  = phase_wr_en_q;
    assign z_corr_mode  = z_corr_mode_q;
    assign busy         = busy_q;
    assign run_done     = run_done_q;
endmodule
